// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported data memory between the CPU
// M stage and a DMA engine. The CPU owns the port by default; DMA takes it
// in CPU-idle cycles. A stalled CPU load keeps its read data in a hold
// register so a DMA access in the stall cycle cannot corrupt it.
//
// Build option: define MEM_ARB_STARVE_GUARD_EN to add a 4-bit DMA wait
// counter that forces a one-cycle DMA slot after MAX_WAIT refused cycles.
// Without it the CPU has strict priority and DMA may starve.
//
// Handshakes: dma_req is a request held stable until dma_gnt is seen high;
// the request is consumed at the clock edge that ends the grant cycle.
// cpu_en low means the CPU request in that cycle was not taken and will be
// presented again. Read data from memory arrives one cycle after mem_re.
module mem_port_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        cpu_en,
    input  logic [3:0]  cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [3:0]  dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic [3:0]  mem_we,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // A 4-bit counter cannot reach a limit above 15; clamp into 1..15.
    localparam logic [3:0] WAIT_LIMIT = (MAX_WAIT < 1)  ? 4'd1  :
                                        (MAX_WAIT > 15) ? 4'd15 : 4'(MAX_WAIT);

    logic        w_en;
    logic        w_cpu_busy;
    logic        w_force;
    logic        w_dma_own;
    logic        w_cpu_own;

    logic        r_dma_rd_pend;
    logic        r_cpu_rd_pend;
    logic        r_hold_valid;
    logic [31:0] r_hold_q;

    // Outputs must read as idle while reset is held, so fold rst_n into the enable.
    assign w_en       = en & rst_n;
    assign w_cpu_busy = (|cpu_we) | cpu_re;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] r_wait_cnt;

    assign w_force = (r_wait_cnt >= WAIT_LIMIT);

    // Count refused DMA cycles; a grant (forced or not) restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
        end else if (en) begin
            if (w_dma_own) begin
                r_wait_cnt <= 4'd0;
            end else if (dma_req && (r_wait_cnt != 4'hF)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end
`else
    // The wait limit only matters with the starvation guard built in.
    logic w_unused_wait_limit;
    assign w_unused_wait_limit = ^WAIT_LIMIT;
    assign w_force             = 1'b0;
`endif

    // Owner selection: DMA in idle CPU cycles or in a forced slot, else CPU.
    assign w_dma_own = w_en & dma_req & (~w_cpu_busy | w_force);
    assign w_cpu_own = w_en & w_cpu_busy & ~w_dma_own;

    assign dma_gnt = w_dma_own;
    assign cpu_en  = w_en & ~(w_dma_own & w_cpu_busy);

    // Memory port mux; with no owner the port is fully idle and zeroed.
    always_comb begin
        mem_we    = 4'h0;
        mem_re    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (w_dma_own) begin
            mem_we    = dma_we;
            mem_re    = ~(|dma_we);
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end else if (w_cpu_own) begin
            mem_we    = cpu_we;
            mem_re    = cpu_re;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Remember that a DMA read was issued so its data is strobed next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dma_rd_pend <= 1'b0;
        end else begin
            r_dma_rd_pend <= w_dma_own & ~(|dma_we);
        end
    end

    assign dma_rvalid = r_dma_rd_pend;
    assign dma_rdata  = r_dma_rd_pend ? mem_rdata : 32'h0;

    // Remember that a CPU load was accepted so its data can be held on a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rd_pend <= 1'b0;
        end else begin
            r_cpu_rd_pend <= w_cpu_own & cpu_re & cpu_en;
        end
    end

    // Capture load data when the CPU stalls in the return cycle; release on
    // the first cycle the CPU pipeline advances again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_q     <= 32'h0;
        end else if (r_cpu_rd_pend && !cpu_en) begin
            r_hold_valid <= 1'b1;
            r_hold_q     <= mem_rdata;
        end else if (cpu_en) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign cpu_rdata = r_hold_valid ? r_hold_q : mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 8; DMA wait cycles before a forced DMA slot (1..15).
REQ-002 Port: clk, input, 1; sole clock, all state on rising edge.
REQ-003 Port: rst_n, input, 1; reset, asynchronous, active-low.
REQ-004 Port: en, input, 1; global enable; low = no grants, no state change except reset.
REQ-005 Port: cpu_en, output, 1; pipeline enable to the CPU.
REQ-006 Ports: cpu_we (in, 4), cpu_re (in, 1), cpu_addr (in, 32), cpu_wdata (in, 32); CPU data-memory request, valid whenever cpu_we!=0 or cpu_re.
REQ-007 Port: cpu_rdata, output, 32; read data returned to the CPU M stage.
REQ-008 Ports: dma_req (in, 1), dma_we (in, 4), dma_addr (in, 32), dma_wdata (in, 32); DMA request, held stable until granted.
REQ-009 Ports: dma_gnt (out, 1), dma_rvalid (out, 1), dma_rdata (out, 32); grant pulse, read-return strobe, read data.
REQ-010 Ports: mem_we (out, 4), mem_re (out, 1), mem_addr (out, 32), mem_wdata (out, 32), mem_rdata (in, 32); single-ported memory, read data valid one cycle after mem_re.

Function
REQ-011 Owner chosen combinationally each cycle: CPU by default; DMA when en & dma_req & (CPU idle, or forced slot).
REQ-012 CPU idle: cpu_we==0 and cpu_re==0.
REQ-013 Memory port muxes owner's we/re/addr/wdata; no owner -> mem_we=0, mem_re=0.
REQ-014 dma_gnt=1 exactly in cycles DMA owns the port; DMA request consumed at that edge.
REQ-015 cpu_en = en & ~(DMA owns port & CPU not idle); CPU request held stalled, replayed next cycle.
REQ-016 dma_rvalid=1 one cycle after a DMA grant with dma_we==0; dma_rdata=mem_rdata in that cycle, else 0.
REQ-017 Registered flag cpu_rd_pend set when CPU owns port with cpu_re & cpu_en; cleared next cycle.
REQ-018 Hold register: when cpu_rd_pend & ~cpu_en, capture mem_rdata, set hold_valid.
REQ-019 cpu_rdata = hold_valid ? hold_q : mem_rdata; hold_valid cleared at first edge with cpu_en=1.
REQ-020 Write to same address by DMA during a CPU hold does not alter held CPU data.
REQ-021 en low: cpu_en=0, dma_gnt=0, memory port idle, counters and hold register frozen.
REQ-022 Byte lanes pass unchanged (cpu_we/dma_we drive mem_we directly).

Reset
REQ-023 rst_n low: cpu_en=0, dma_gnt=0, dma_rvalid=0, dma_rdata=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
REQ-024 rst_n low: wait counter=0, cpu_rd_pend=0, hold_valid=0, hold_q=0.
REQ-025 Reset mid-transfer discards pending DMA read return; no dma_rvalid after release.

Configuration
REQ-026 Macro MEM_ARB_STARVE_GUARD_EN defined: 4-bit saturating wait counter increments each en cycle with dma_req & ~dma_gnt, clears on grant.
REQ-027 With macro: counter >= MAX_WAIT forces DMA ownership for one cycle even if CPU busy (REQ-015 stall applies).
REQ-028 With macro: counter clears on forced grant, so forced slots are never back-to-back.
REQ-029 Without macro: strict CPU priority, no counter, DMA granted only in CPU-idle cycles, starvation allowed.

Verification
REQ-030 Reset: rst_n=0 with en=1, dma_req=1 -> all outputs 0; after release, first edge grants nothing until en sampled.
REQ-031 CPU idle, dma_req=1, dma_addr=0x100, dma_we=0 -> dma_gnt=1 same cycle, cpu_en=1, dma_rvalid=1 next cycle with mem word at 0x100.
REQ-032 CPU busy every cycle, dma_req=1, guard on, MAX_WAIT=8 -> dma_gnt on 9th cycle, cpu_en=0 exactly that cycle, CPU access replayed after.
REQ-033 Same as previous, guard off -> dma_gnt never asserts over 100 cycles, cpu_en=1 throughout.
REQ-034 CPU lw 0x200 (word 0xDEADBEEF) followed by forced DMA write 0x200=0x0 -> cpu_rdata stays 0xDEADBEEF until cpu_en returns high.
REQ-035 en=0 for 5 cycles mid-wait (counter=5) -> no grants, counter holds 5, resumes counting after en=1.
